// File: rtl/can_crc15_chk.sv
// ---------------------------------------------------------------------------
// can_crc15_chk
//
// Receive-side CRC15 checker for the CAN controller. It accumulates the CAN
// CRC15 over the destuffed bit stream from SOF through the last covered bit,
// captures the 15 received CRC bits, samples the CRC delimiter and reports
// the outcome to the receive FSM and the error-management logic.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active-high
//   rx_bit       destuffed received bit
//   rx_bit_valid one-cycle strobe per sample point; qualifies the inputs below
//   frame_start  high with the SOF bit; starts a new check
//   calc_end     high with the last CRC-covered bit
//   abort        error frame / bus-off; acts on any cycle
//   busy         high while in CALC, RECV or DELIM
//   crc_calc     running or final computed CRC
//   crc_rx       received CRC field, MSB first
//   crc_done     one-cycle pulse when the result is valid
//   crc_ok       sticky: computed == received and delimiter recessive
//   crc_err      sticky: computed != received
//   form_err     sticky: CRC delimiter sampled dominant
// ---------------------------------------------------------------------------
module can_crc15_chk #(
    parameter logic [14:0] CRC_POLY = 15'h4599,
    parameter int          CRC_W    = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_bit,
    input  logic             rx_bit_valid,
    input  logic             frame_start,
    input  logic             calc_end,
    input  logic             abort,
    output logic             busy,
    output logic [CRC_W-1:0] crc_calc,
    output logic [CRC_W-1:0] crc_rx,
    output logic             crc_done,
    output logic             crc_ok,
    output logic             crc_err,
    output logic             form_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CALC  = 3'd1,
        RECV  = 3'd2,
        DELIM = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t     state, state_next;
    logic [3:0] cnt;

    // One serial step of the CAN CRC15 LFSR.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc,
                                                  input logic             b);
        logic fb;
        fb = b ^ crc[CRC_W-1];
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : {CRC_W{1'b0}});
    endfunction

    // Next-state logic. DONE lasts exactly one cycle regardless of
    // rx_bit_valid so that crc_done is a single-cycle pulse.
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else if (rx_bit_valid && frame_start) begin
            state_next = calc_end ? RECV : CALC;
        end else if (state == DONE) begin
            state_next = IDLE;
        end else if (rx_bit_valid) begin
            unique case (state)
                CALC:    if (calc_end) state_next = RECV;
                RECV:    if (cnt == 4'd14) state_next = DELIM;
                DELIM:   state_next = DONE;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath and sticky result flags. An abort clears the flags but keeps
    // crc_calc/crc_rx so the last values stay visible for debugging.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_calc <= '0;
            crc_rx   <= '0;
            cnt      <= '0;
            crc_ok   <= 1'b0;
            crc_err  <= 1'b0;
            form_err <= 1'b0;
        end else if (abort) begin
            crc_ok   <= 1'b0;
            crc_err  <= 1'b0;
            form_err <= 1'b0;
        end else if (rx_bit_valid) begin
            if (frame_start) begin
                // SOF is folded into a freshly cleared register.
                crc_calc <= crc_step('0, rx_bit);
                crc_rx   <= '0;
                cnt      <= '0;
                crc_ok   <= 1'b0;
                crc_err  <= 1'b0;
                form_err <= 1'b0;
            end else begin
                unique case (state)
                    CALC: begin
                        crc_calc <= crc_step(crc_calc, rx_bit);
                        cnt      <= '0;
                    end
                    RECV: begin
                        crc_rx <= {crc_rx[CRC_W-2:0], rx_bit};
                        cnt    <= (cnt == 4'd14) ? 4'd0 : cnt + 4'd1;
                    end
                    DELIM: begin
                        form_err <= ~rx_bit;
                        crc_err  <= (crc_calc != crc_rx);
                        crc_ok   <= rx_bit & (crc_calc == crc_rx);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy     = (state == CALC) || (state == RECV) || (state == DELIM);
    assign crc_done = (state == DONE);

endmodule
